// File: rtl/cla_arbiter.sv
// cla_arbiter: round-robin arbiter feeding four requesters' operand pairs through one shared carry-lookahead adder.
module Carry_Look_Ahead_Adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);
  logic [WIDTH-1:0] p, g;
  logic [WIDTH:0] c;
  logic t;
  assign p = a_i ^ b_i;
  assign g = a_i & b_i;
  // Each carry inside a group is expanded from the group carry-in, so only group carries chain.
  always_comb begin
    c = '0;
    t = 1'b0;
    c[0] = c_i;
    for (int k = 0; k < WIDTH; k += GROUP)
      for (int j = 1; j <= GROUP; j++) begin
        t = c[k];
        for (int n = 0; n < j; n++) t = g[k+n] | (p[k+n] & t);
        c[k+j] = t;
      end
  end
  assign sum_o = p ^ c[WIDTH-1:0];
  assign c_o = c[WIDTH];
endmodule

module cla_arbiter #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic [WIDTH:0]     rsp_sum
);
  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
  state_t state_q;
  logic [1:0] last_q, id_q, win_d, rsp_id_q;
  logic found_d, cout_d, rsp_valid_q;
  logic [WIDTH-1:0] a_q, b_q, sum_d;
  logic [WIDTH:0] rsp_sum_q;
  // Search starts just past the last winner and wraps.
  always_comb begin
    win_d = '0;
    found_d = 1'b0;
    for (int k = 1; k <= 4; k++)
      if (!found_d && req_valid[last_q + 2'(k)]) begin
        found_d = 1'b1;
        win_d = last_q + 2'(k);
      end
  end
  assign req_ready = (state_q == IDLE && !rst && found_d) ? 4'b0001 << win_d : 4'b0000;
  Carry_Look_Ahead_Adder #(.WIDTH(WIDTH), .GROUP(GROUP)) u_add (
    .a_i(a_q),
    .b_i(b_q),
    .c_i(1'b0),
    .sum_o(sum_d),
    .c_o(cout_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 2'd3;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_sum_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (found_d) begin
          a_q <= req_a[win_d*WIDTH +: WIDTH];
          b_q <= req_b[win_d*WIDTH +: WIDTH];
          id_q <= win_d;
          last_q <= win_d;
          state_q <= ADD;
        end
        ADD: begin
          rsp_sum_q <= {cout_d, sum_d};
          rsp_id_q <= id_q;
          rsp_valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_sum = rsp_sum_q;
endmodule

// File: tb/tb_cla_arbiter.sv
// tb_cla_arbiter: directed scenarios plus random traffic against a transaction-level reference model.
module tb_cla_arbiter;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst, rsp_ready, rsp_valid;
  logic [3:0] v, req_ready;
  logic [W-1:0] opa[4], opb[4];
  logic [4*W-1:0] req_a, req_b;
  logic [1:0] rsp_id;
  logic [W:0] rsp_sum;
  int total = 0, bad = 0, cyc = 0;
  int m_last = 3, m_age = 0, p_id = 0, m_id = 0;
  bit m_busy = 0;
  logic [W:0] p_sum = '0, m_sum = '0;
  logic [3:0] granted;
  int gq[$], gc[$];
  int rsp_n;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 4; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end

  cla_arbiter #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(v),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_sum(rsp_sum)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(logic [3:0] vv, int last);
    for (int k = 1; k <= 4; k++)
      if (vv[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic int onehot_idx(logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic sample();
    int w;
    logic [3:0] e;
    @(negedge clk);
    w = rr_pick(v, m_last);
    e = (!rst && !m_busy && w >= 0) ? 4'b0001 << w : 4'b0000;
    chk("ready", req_ready, e);
    chk("valid", rsp_valid, m_busy && m_age == 1);
    chk("sum", rsp_sum, m_sum);
    chk("id", rsp_id, m_id);
  endtask

  task automatic advance();
    int w;
    @(posedge clk);
    granted = '0;
    if (rst) begin
      m_busy = 0;
      m_last = 3;
      m_sum = '0;
      m_id = 0;
    end else if (!m_busy) begin
      w = rr_pick(v, m_last);
      if (w >= 0) begin
        m_busy = 1;
        m_age = 0;
        p_id = w;
        p_sum = {1'b0, opa[w]} + {1'b0, opb[w]};
        m_last = w;
        granted[w] = 1'b1;
      end
    end else if (m_age == 0) begin
      m_age = 1;
      m_sum = p_sum;
      m_id = p_id;
    end else if (rsp_ready) m_busy = 0;
    cyc++;
    #1;
    v = v & ~granted;
  endtask

  task automatic drain();
    for (int c = 0; c < 30 && (v != 0 || m_busy); c++) begin
      sample();
      advance();
    end
  endtask

  // A requester that was valid and not granted must keep its request and operands unchanged.
  logic [3:0] pv, pr;
  logic [W-1:0] pa[4], pb[4];
  bit have = 0;
  always @(posedge clk) begin
    if (have)
      for (int i = 0; i < 4; i++)
        if (pv[i] && !pr[i]) chk("hold", {v[i], opa[i], opb[i]}, {1'b1, pa[i], pb[i]});
    pv <= v;
    pr <= req_ready;
    pa <= opa;
    pb <= opb;
    have <= 1'b1;
  end

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    opa[2] = 120;
    opb[2] = 200;
    v = 4'b0100;
    sample();
    chk("rst_rdy", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_id", rsp_id, 0);
    advance();
    rst = 1'b0;
    sample();
    chk("s031_rdy", req_ready, 4'b0100);
    advance();
    sample();
    advance();
    sample();
    chk("s031_valid", rsp_valid, 1);
    chk("s031_id", rsp_id, 2);
    chk("s031_sum", rsp_sum, 320);
    advance();

    opa[0] = 16'hFFFF;
    opb[0] = 16'hFFFF;
    v = 4'b0001;
    sample();
    advance();
    sample();
    advance();
    sample();
    chk("s032_sum", rsp_sum, 'h1FFFE);
    chk("s032_id", rsp_id, 0);
    advance();

    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      opa[i] = W'(i);
      opb[i] = W'(i * 10);
    end
    gq.delete();
    gc.delete();
    rsp_n = 0;
    for (int c = 0; c < 15; c++) begin
      v = 4'hF;
      sample();
      if (req_ready != 0) begin
        gq.push_back(onehot_idx(req_ready));
        gc.push_back(cyc);
      end
      if (rsp_valid) begin
        chk("s033_rid", rsp_id, rsp_n % 4);
        chk("s033_rsum", rsp_sum, 11 * (rsp_n % 4));
        rsp_n++;
      end
      advance();
    end
    chk("s033_ngrant", gq.size(), 5);
    chk("s033_nrsp", rsp_n, 5);
    for (int k = 0; k < gq.size(); k++) chk("s033_order", gq[k], k % 4);
    for (int k = 1; k < gc.size(); k++) chk("s033_gap", gc[k] - gc[k-1], 3);
    drain();

    opa[1] = 5;
    opb[1] = 7;
    v = 4'b0010;
    rsp_ready = 1'b0;
    sample();
    chk("s034_rdy", req_ready, 4'b0010);
    advance();
    opa[3] = 1;
    opb[3] = 2;
    v = 4'b1000;
    sample();
    advance();
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("s034_valid", rsp_valid, 1);
      chk("s034_sum", rsp_sum, 12);
      chk("s034_rdy0", req_ready, 0);
      advance();
    end
    rsp_ready = 1'b1;
    sample();
    advance();
    sample();
    chk("s034_idle_rdy", req_ready, 4'b1000);
    advance();
    drain();

    opa[1] = 9;
    opb[1] = 9;
    opa[2] = 4;
    opb[2] = 4;
    v = 4'b0110;
    sample();
    advance();
    sample();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    v = 4'b0110;
    sample();
    chk("s035_valid", rsp_valid, 0);
    chk("s035_sum", rsp_sum, 0);
    chk("s035_rdy", req_ready, 4'b0010);
    advance();
    sample();
    chk("s035_valid2", rsp_valid, 0);
    advance();
    drain();

    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    gq.delete();
    for (int c = 0; c < 20; c++) begin
      v = 4'b1010;
      sample();
      if (req_ready != 0) gq.push_back(onehot_idx(req_ready));
      advance();
    end
    chk("s036_ngrant", gq.size(), 7);
    for (int k = 0; k < gq.size(); k++) chk("s036_order", gq[k], (k % 2) ? 3 : 1);
    drain();

    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++)
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          opa[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
          opb[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
          v[i] = 1'b1;
        end
      sample();
      advance();
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cla_arbiter.md
CLA_ARBITER -- requirements
Module: cla_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, must be divisible by GROUP.
REQ-002 Parameter GROUP, default 4: lookahead group size passed to the internal Carry_Look_Ahead_Adder.
REQ-003 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset, sampled on clk rising edge.
REQ-005 Port req_valid  input  4: per-requester operand-pair valid; bit i belongs to requester i.
REQ-006 Port req_a  input  4*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port req_b  input  4*WIDTH: operand B; same packing as req_a.
REQ-008 Port req_ready  output  4: one-hot or zero grant/accept strobe.
REQ-009 Port rsp_valid  output  1: result available.
REQ-010 Port rsp_ready  input  1: consumer accepts the result.
REQ-011 Port rsp_id  output  2: index of the requester that owns rsp_sum.
REQ-012 Port rsp_sum  output  WIDTH+1: A+B, with the MSB as carry-out.

Function
REQ-013 The block SHALL contain exactly one Carry_Look_Ahead_Adder #(WIDTH,GROUP) instance, shared by all four requesters.
REQ-014 FSM states SHALL be IDLE, ADD and RESP.
REQ-015 In IDLE, req_ready SHALL assert combinationally for the single winning requester among the set req_valid bits; it SHALL be 0 in ADD and RESP.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4, ascending and wrapping.
REQ-017 last_grant SHALL update to the winner's index on acceptance only.
REQ-018 Acceptance SHALL occur when req_valid[i] & req_ready[i] at a clock edge; on acceptance, req_a/req_b slice i and id i SHALL be captured into operand registers, and the FSM SHALL go to ADD.
REQ-019 In ADD, the registered operands SHALL drive the adder; at the end of the cycle, the adder output SHALL be registered into rsp_sum, the captured id into rsp_id, and the FSM SHALL go to RESP.
REQ-020 In RESP, rsp_valid SHALL be 1 and rsp_sum/rsp_id SHALL remain stable until rsp_valid & rsp_ready; the FSM SHALL then return to IDLE.
REQ-021 Latency SHALL be: acceptance edge at cycle T, rsp_valid high from cycle T+2; minimum issue interval is 3 cycles.
REQ-022 With no req_valid bit set, the FSM SHALL remain in IDLE with all outputs at their reset values, apart from holding rsp_sum/rsp_id.
REQ-023 A requester SHALL hold req_valid and its operands stable until granted; a bench assertion SHALL flag any violation.
REQ-024 Sum arithmetic SHALL be unsigned, with no truncation: 0xFFFF+0xFFFF at WIDTH=16 yields 0x1FFFE.
REQ-025 If rsp_ready is held low, the block SHALL stall indefinitely in RESP, and no new request SHALL be accepted.
REQ-026 If rsp_ready is high on the first RESP cycle, the result SHALL be consumed that cycle, and IDLE SHALL be reached on the next edge.

Reset
REQ-027 With rst high at a clock edge, the FSM SHALL go to IDLE and rsp_valid SHALL be 0.
REQ-028 Reset SHALL set rsp_sum to 0, rsp_id to 0, the operand registers to 0, and last_grant to 3, so that requester 0 has first priority.
REQ-029 Reset asserted in ADD or RESP SHALL discard the in-flight result; no rsp_valid pulse SHALL follow.
REQ-030 req_ready SHALL be 0 during any cycle in which rst is high.

Verification
REQ-031 Single request: after reset, requester 2 presents a=120, b=200 -> req_ready=0100 that cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_sum=320.
REQ-032 Carry-out: requester 0 presents a=0xFFFF, b=0xFFFF -> rsp_sum=0x1FFFE, rsp_id=0.
REQ-033 Round-robin: all four requesters valid continuously, rsp_ready=1, operands i and i*10 -> rsp_id order 0,1,2,3,0 and rsp_sum = 11*i; grants spaced 3 cycles apart.
REQ-034 Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, rsp_sum stays stable and req_ready stays 0000; rsp_ready=1 -> IDLE on the next edge.
REQ-035 Reset mid-operation: rst pulsed 1 cycle while in ADD -> next cycle IDLE, rsp_valid=0, rsp_sum=0, and the next grant goes to the lowest valid index.
REQ-036 Fairness: requesters 1 and 3 continuously valid -> grants alternate 1,3,1,3, with neither starved.
